// File: rtl/rv_pkg.sv
// Shared RV decode constants: major opcodes, issue FSM encoding, immediate formats.
package rv_pkg;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_BR_WAIT   = 2'd1,
    ST_TRAP_WAIT = 2'd2
  } issue_state_t;

  // funct12 values of the SYSTEM ops that leave a trap/xRET outstanding
  function automatic logic is_trap_op(input logic [31:0] ir);
    return (ir[6:0] == SYSTEM) && (ir[14:12] == 3'b000) &&
           ((ir[31:20] == 12'h000) || (ir[31:20] == 12'h001) || (ir[31:20] == 12'h302));
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux for one source operand; index 0 is the youngest producer.
module fwd_select #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 3
) (
  input  logic [NUM_FWD-1:0]      fwd_v,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]      fwd_pend,
  input  logic [4:0]              rs,
  input  logic [XLEN-1:0]         rf_data,
  output logic [XLEN-1:0]         data,
  output logic                    pend
);

  logic [NUM_FWD-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_hit
      assign hit[gi] = fwd_v[gi] && (fwd_rd[5*gi +: 5] == rs) && (rs != 5'd0);
    end
  endgenerate

  // Walk oldest to youngest so the lowest matching index is the last writer.
  always_comb begin
    data = (rs == 5'd0) ? '0 : rf_data;
    pend = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (hit[i]) begin
        data = fwd_data[XLEN*i +: XLEN];
        pend = fwd_pend[i];
      end
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: immediate generation, operand forwarding, load-use interlock,
// branch/trap issue hold and the EXE latch with a valid/ready handshake.
module decode_issue_stage
  import rv_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NUM_FWD  = 3,
  parameter int CNT_W    = 16,
  parameter int BR_STALL = 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    DE_V,
  input  logic [31:0]             DE_IR,
  input  logic [XLEN-1:0]         DE_PC,
  output logic                    DE_READY,
  output logic [4:0]              RF_RS1_ADDR,
  output logic [4:0]              RF_RS2_ADDR,
  input  logic [XLEN-1:0]         RF_RS1_DATA,
  input  logic [XLEN-1:0]         RF_RS2_DATA,
  input  logic [NUM_FWD-1:0]      FWD_V,
  input  logic [5*NUM_FWD-1:0]    FWD_RD,
  input  logic [XLEN*NUM_FWD-1:0] FWD_DATA,
  input  logic [NUM_FWD-1:0]      FWD_PEND,
  input  logic                    FLUSH,
  input  logic                    BR_RESOLVE,
  input  logic                    TRAP_DONE,
  input  logic                    EXE_READY,
  output logic                    EXE_V,
  output logic [31:0]             EXE_IR,
  output logic [XLEN-1:0]         EXE_PC,
  output logic [XLEN-1:0]         EXE_OP1,
  output logic [XLEN-1:0]         EXE_OP2,
  output logic [XLEN-1:0]         EXE_RS2,
  output logic [XLEN-1:0]         EXE_IMM,
  output logic                    EXE_CTRL,
  output logic                    EXE_TRAP,
  output logic [CNT_W-1:0]        HAZ_CNT
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            rs1_used;
  logic            rs2_used;
  logic            is_shift;
  logic            is_ctrl;
  logic            is_trap;
  logic            hazard;
  logic            can_issue;
  logic            fire;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  logic [4:0]      src_rs   [2];
  logic [XLEN-1:0] src_rf   [2];
  logic [XLEN-1:0] src_val  [2];
  logic            src_pend [2];

  issue_state_t    state_reg;
  logic            exe_v_reg;
  logic [31:0]     exe_ir_reg;
  logic [XLEN-1:0] exe_pc_reg;
  logic [XLEN-1:0] exe_op1_reg;
  logic [XLEN-1:0] exe_op2_reg;
  logic [XLEN-1:0] exe_rs2_reg;
  logic [XLEN-1:0] exe_imm_reg;
  logic            exe_ctrl_reg;
  logic            exe_trap_reg;
  logic [CNT_W-1:0] haz_cnt_reg;

  assign opcode      = DE_IR[6:0];
  assign funct3      = DE_IR[14:12];
  assign RF_RS1_ADDR = DE_IR[19:15];
  assign RF_RS2_ADDR = DE_IR[24:20];

  assign src_rs[0] = DE_IR[19:15];
  assign src_rs[1] = DE_IR[24:20];
  assign src_rf[0] = RF_RS1_DATA;
  assign src_rf[1] = RF_RS2_DATA;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
      ) u_fwd (
        .fwd_v    (FWD_V),
        .fwd_rd   (FWD_RD),
        .fwd_data (FWD_DATA),
        .fwd_pend (FWD_PEND),
        .rs       (src_rs[gi]),
        .rf_data  (src_rf[gi]),
        .data     (src_val[gi]),
        .pend     (src_pend[gi])
      );
    end
  endgenerate

  // CSR register forms read rs1; the immediate forms (funct3[2]=1) do not.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP, OP_32, STORE, BRANCH:        begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_IMM, OP_IMM_32, LOAD, JALR:   rs1_used = 1'b1;
      SYSTEM:                          rs1_used = (funct3 != 3'b000) && !funct3[2];
      default:                         ;
    endcase
  end

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign is_ctrl  = (opcode == BRANCH) || (opcode == JAL) || (opcode == JALR);
  assign is_trap  = is_trap_op(DE_IR);

  always_comb begin
    imm = '0;
    case (opcode)
      OP_IMM: begin
        if (is_shift)
          imm = (XLEN == 64) ? XLEN'(DE_IR[25:20]) : XLEN'(DE_IR[24:20]);
        else
          imm = XLEN'($signed(DE_IR[31:20]));
      end
      OP_IMM_32: begin
        if (is_shift)
          imm = XLEN'(DE_IR[24:20]);
        else
          imm = XLEN'($signed(DE_IR[31:20]));
      end
      LOAD, JALR, SYSTEM: imm = XLEN'($signed(DE_IR[31:20]));
      STORE:        imm = XLEN'($signed({DE_IR[31:25], DE_IR[11:7]}));
      BRANCH:       imm = XLEN'($signed({DE_IR[31], DE_IR[7], DE_IR[30:25], DE_IR[11:8], 1'b0}));
      LUI, AUIPC:   imm = XLEN'($signed({DE_IR[31:12], 12'h000}));
      JAL:          imm = XLEN'($signed({DE_IR[31], DE_IR[19:12], DE_IR[20], DE_IR[30:21], 1'b0}));
      default:      imm = '0;
    endcase
  end

  always_comb begin
    case (opcode)
      AUIPC, JAL: op1 = DE_PC;
      LUI:        op1 = '0;
      default:    op1 = src_val[0];
    endcase
    case (opcode)
      OP, OP_32, BRANCH: op2 = src_val[1];
      default:           op2 = imm;
    endcase
  end

  assign hazard    = (rs1_used && src_pend[0]) || (rs2_used && src_pend[1]);
  assign can_issue = (state_reg == ST_RUN) && !hazard && (!exe_v_reg || EXE_READY) && !FLUSH;
  assign fire      = DE_V && can_issue;
  assign DE_READY  = can_issue;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg    <= ST_RUN;
      exe_v_reg    <= 1'b0;
      exe_ir_reg   <= NOP_INSN;
      exe_pc_reg   <= '0;
      exe_op1_reg  <= '0;
      exe_op2_reg  <= '0;
      exe_rs2_reg  <= '0;
      exe_imm_reg  <= '0;
      exe_ctrl_reg <= 1'b0;
      exe_trap_reg <= 1'b0;
      haz_cnt_reg  <= '0;
    end else begin
      if (FLUSH) begin
        exe_v_reg <= 1'b0;
      end else if (fire) begin
        exe_v_reg    <= 1'b1;
        exe_ir_reg   <= DE_IR;
        exe_pc_reg   <= DE_PC;
        exe_op1_reg  <= op1;
        exe_op2_reg  <= op2;
        exe_rs2_reg  <= src_val[1];
        exe_imm_reg  <= imm;
        exe_ctrl_reg <= is_ctrl;
        exe_trap_reg <= is_trap;
      end else if (EXE_READY) begin
        exe_v_reg <= 1'b0;
      end

      if (FLUSH) begin
        state_reg <= ST_RUN;
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (fire && is_trap)
              state_reg <= ST_TRAP_WAIT;
            else if (fire && is_ctrl && (BR_STALL != 0))
              state_reg <= ST_BR_WAIT;
          end
          ST_BR_WAIT:   if (BR_RESOLVE) state_reg <= ST_RUN;
          ST_TRAP_WAIT: if (TRAP_DONE)  state_reg <= ST_RUN;
          default:      state_reg <= ST_RUN;
        endcase
      end

      if (DE_V && (state_reg == ST_RUN) && hazard && !FLUSH && (haz_cnt_reg != {CNT_W{1'b1}}))
        haz_cnt_reg <= haz_cnt_reg + CNT_W'(1);
    end
  end

  assign EXE_V    = exe_v_reg;
  assign EXE_IR   = exe_ir_reg;
  assign EXE_PC   = exe_pc_reg;
  assign EXE_OP1  = exe_op1_reg;
  assign EXE_OP2  = exe_op2_reg;
  assign EXE_RS2  = exe_rs2_reg;
  assign EXE_IMM  = exe_imm_reg;
  assign EXE_CTRL = exe_ctrl_reg;
  assign EXE_TRAP = exe_trap_reg;
  assign HAZ_CNT  = haz_cnt_reg;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: expected issues are queued when driven and
// popped when the EXE latch presents them.
module tb_decode_issue_stage;

  localparam int XLEN    = 64;
  localparam int NUM_FWD = 3;
  localparam int CNT_W   = 4;

  localparam logic [31:0] I_ADDI  = 32'hFFF0_0093; // addi x1,x0,-1
  localparam logic [31:0] I_ADD55 = 32'h0052_8333; // add x6,x5,x5
  localparam logic [31:0] I_ADD00 = 32'h0000_0333; // add x6,x0,x0
  localparam logic [31:0] I_ADD52 = 32'h0022_83B3; // add x7,x5,x2
  localparam logic [31:0] I_SD    = 32'hFE20_BC23; // sd x2,-8(x1)
  localparam logic [31:0] I_SLLI  = 32'h0210_9093; // slli x1,x1,33
  localparam logic [31:0] I_LUI   = 32'h8000_01B7; // lui x3,0x80000
  localparam logic [31:0] I_BEQ   = 32'h0020_8463; // beq x1,x2,+8
  localparam logic [31:0] I_JAL   = 32'h0100_00EF; // jal x1,+16
  localparam logic [31:0] I_ECALL = 32'h0000_0073;
  localparam logic [63:0] RF1     = 64'h1111;
  localparam logic [63:0] RF2     = 64'h2222;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                    CLK = 1'b0;
  logic                    RESET_N;
  logic                    DE_V;
  logic [31:0]             DE_IR;
  logic [XLEN-1:0]         DE_PC;
  logic                    DE_READY;
  logic [4:0]              RF_RS1_ADDR;
  logic [4:0]              RF_RS2_ADDR;
  logic [XLEN-1:0]         RF_RS1_DATA;
  logic [XLEN-1:0]         RF_RS2_DATA;
  logic [NUM_FWD-1:0]      FWD_V;
  logic [5*NUM_FWD-1:0]    FWD_RD;
  logic [XLEN*NUM_FWD-1:0] FWD_DATA;
  logic [NUM_FWD-1:0]      FWD_PEND;
  logic                    FLUSH;
  logic                    BR_RESOLVE;
  logic                    TRAP_DONE;
  logic                    EXE_READY;
  logic                    EXE_V;
  logic [31:0]             EXE_IR;
  logic [XLEN-1:0]         EXE_PC;
  logic [XLEN-1:0]         EXE_OP1;
  logic [XLEN-1:0]         EXE_OP2;
  logic [XLEN-1:0]         EXE_RS2;
  logic [XLEN-1:0]         EXE_IMM;
  logic                    EXE_CTRL;
  logic                    EXE_TRAP;
  logic [CNT_W-1:0]        HAZ_CNT;

  typedef struct {
    logic [31:0] ir;
    logic [63:0] pc;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic        ctrl;
    logic        trap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  decode_issue_stage #(
    .XLEN     (XLEN),
    .NUM_FWD  (NUM_FWD),
    .CNT_W    (CNT_W),
    .BR_STALL (1)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DE_V        (DE_V),
    .DE_IR       (DE_IR),
    .DE_PC       (DE_PC),
    .DE_READY    (DE_READY),
    .RF_RS1_ADDR (RF_RS1_ADDR),
    .RF_RS2_ADDR (RF_RS2_ADDR),
    .RF_RS1_DATA (RF_RS1_DATA),
    .RF_RS2_DATA (RF_RS2_DATA),
    .FWD_V       (FWD_V),
    .FWD_RD      (FWD_RD),
    .FWD_DATA    (FWD_DATA),
    .FWD_PEND    (FWD_PEND),
    .FLUSH       (FLUSH),
    .BR_RESOLVE  (BR_RESOLVE),
    .TRAP_DONE   (TRAP_DONE),
    .EXE_READY   (EXE_READY),
    .EXE_V       (EXE_V),
    .EXE_IR      (EXE_IR),
    .EXE_PC      (EXE_PC),
    .EXE_OP1     (EXE_OP1),
    .EXE_OP2     (EXE_OP2),
    .EXE_RS2     (EXE_RS2),
    .EXE_IMM     (EXE_IMM),
    .EXE_CTRL    (EXE_CTRL),
    .EXE_TRAP    (EXE_TRAP),
    .HAZ_CNT     (HAZ_CNT)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_de(input logic v, input logic [31:0] ir, input logic [63:0] pc);
    DE_V  = v;
    DE_IR = ir;
    DE_PC = pc;
  endtask

  task automatic push_exp(input logic [31:0] ir, input logic [63:0] pc, input logic [63:0] op1,
                          input logic [63:0] op2, input logic [63:0] rs2, input logic [63:0] imm,
                          input logic ctrl, input logic trap);
    exp_t e;
    e.ir = ir; e.pc = pc; e.op1 = op1; e.op2 = op2;
    e.rs2 = rs2; e.imm = imm; e.ctrl = ctrl; e.trap = trap;
    sb.push_back(e);
  endtask

  task automatic check_issue(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s observed=no_expected_entry expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".v"},    64'(EXE_V),    64'd1);
      chk({tag, ".ir"},   64'(EXE_IR),   64'(e.ir));
      chk({tag, ".pc"},   EXE_PC,        e.pc);
      chk({tag, ".op1"},  EXE_OP1,       e.op1);
      chk({tag, ".op2"},  EXE_OP2,       e.op2);
      chk({tag, ".rs2"},  EXE_RS2,       e.rs2);
      chk({tag, ".imm"},  EXE_IMM,       e.imm);
      chk({tag, ".ctrl"}, 64'(EXE_CTRL), 64'(e.ctrl));
      chk({tag, ".trap"}, 64'(EXE_TRAP), 64'(e.trap));
      $display("issue %s ir=%h pc=%0h op1=%0h op2=%0h", tag, EXE_IR, EXE_PC, EXE_OP1, EXE_OP2);
    end
  endtask

  // Issue with DE_READY expected high this cycle, then check the EXE latch.
  task automatic issue(input string tag, input logic [31:0] ir, input logic [63:0] pc);
    drive_de(1'b1, ir, pc);
    settle();
    chk({tag, ".de_ready"}, 64'(DE_READY), 64'd1);
    tick();
    check_issue(tag);
  endtask

  initial begin
    RESET_N = 1'b0; drive_de(1'b0, 32'h0, 64'h0);
    RF_RS1_DATA = RF1; RF_RS2_DATA = RF2;
    FWD_V = '0; FWD_RD = '0; FWD_DATA = '0; FWD_PEND = '0;
    FLUSH = 1'b0; BR_RESOLVE = 1'b0; TRAP_DONE = 1'b0; EXE_READY = 1'b1;
    tick(); tick();
    chk("rst.exe_v",   64'(EXE_V),   64'd0);
    chk("rst.exe_ir",  64'(EXE_IR),  64'h13);
    chk("rst.op1",     EXE_OP1,      64'd0);
    chk("rst.imm",     EXE_IMM,      64'd0);
    chk("rst.haz_cnt", 64'(HAZ_CNT), 64'd0);
    RESET_N = 1'b1;

    // Negative I-immediate, x0 source
    drive_de(1'b1, I_ADDI, 64'h100);
    settle();
    chk("addi.rs1_addr", 64'(RF_RS1_ADDR), 64'd0);
    chk("addi.rs2_addr", 64'(RF_RS2_ADDR), 64'd31);
    push_exp(I_ADDI, 64'h100, 64'd0, ONES, RF2, ONES, 1'b0, 1'b0);
    issue("addi", I_ADDI, 64'h100);

    // Youngest matching source wins
    FWD_V = 3'b011; FWD_RD = {5'd0, 5'd5, 5'd5};
    FWD_DATA = {64'h0, 64'hBB, 64'hAA};
    push_exp(I_ADD55, 64'h104, 64'hAA, 64'hAA, 64'hAA, 64'd0, 1'b0, 1'b0);
    issue("fwd_prio", I_ADD55, 64'h104);

    // Forwarding to x0 never applies
    FWD_RD = {5'd0, 5'd0, 5'd0};
    push_exp(I_ADD00, 64'h108, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    issue("fwd_x0", I_ADD00, 64'h108);

    // Each operand selects its own source
    FWD_V = 3'b110; FWD_RD = {5'd2, 5'd5, 5'd0};
    FWD_DATA = {64'hCC, 64'hBB, 64'hAA};
    push_exp(I_ADD52, 64'h10C, 64'hBB, 64'hCC, 64'hCC, 64'd0, 1'b0, 1'b0);
    issue("fwd_indep", I_ADD52, 64'h10C);

    // Load-use interlock
    FWD_V = 3'b001; FWD_RD = {5'd0, 5'd0, 5'd5};
    FWD_DATA = {64'h0, 64'h0, 64'hDD}; FWD_PEND = 3'b001;
    drive_de(1'b1, I_ADD52, 64'h110);
    settle();
    chk("ldu.de_ready", 64'(DE_READY), 64'd0);
    tick();
    chk("ldu.exe_v_drop", 64'(EXE_V), 64'd0);
    chk("ldu.haz1", 64'(HAZ_CNT), 64'd1);
    chk("ldu.de_ready2", 64'(DE_READY), 64'd0);
    tick();
    chk("ldu.haz2", 64'(HAZ_CNT), 64'd2);
    FWD_PEND = 3'b000;
    push_exp(I_ADD52, 64'h110, 64'hDD, RF2, RF2, 64'd0, 1'b0, 1'b0);
    issue("ldu_release", I_ADD52, 64'h110);
    chk("ldu.haz_hold", 64'(HAZ_CNT), 64'd2);

    // EXE back-pressure keeps payload stable
    FWD_V = 3'b000; EXE_READY = 1'b0;
    drive_de(1'b1, I_SD, 64'h114);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp.de_ready", 64'(DE_READY), 64'd0);
      tick();
      chk("bp.exe_v",   64'(EXE_V),   64'd1);
      chk("bp.exe_ir",  64'(EXE_IR),  64'(I_ADD52));
      chk("bp.exe_op1", EXE_OP1,      64'hDD);
    end
    EXE_READY = 1'b1;
    push_exp(I_SD, 64'h114, RF1, 64'hFFFF_FFFF_FFFF_FFF8, RF2, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    issue("store", I_SD, 64'h114);

    push_exp(I_SLLI, 64'h118, RF1, 64'd33, RF2, 64'd33, 1'b0, 1'b0);
    issue("slli64", I_SLLI, 64'h118);

    push_exp(I_LUI, 64'h11C, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    issue("lui", I_LUI, 64'h11C);

    // Branch holds issue until resolved
    push_exp(I_BEQ, 64'h200, RF1, RF2, RF2, 64'd8, 1'b1, 1'b0);
    issue("beq", I_BEQ, 64'h200);
    drive_de(1'b1, I_ADDI, 64'h204);
    settle();
    chk("brw.de_ready", 64'(DE_READY), 64'd0);
    tick();
    chk("brw.exe_v", 64'(EXE_V), 64'd0);
    chk("brw.de_ready2", 64'(DE_READY), 64'd0);
    BR_RESOLVE = 1'b1;
    settle();
    chk("brw.de_ready_resolve", 64'(DE_READY), 64'd0);
    tick();
    BR_RESOLVE = 1'b0;
    push_exp(I_ADDI, 64'h204, 64'd0, ONES, RF2, ONES, 1'b0, 1'b0);
    issue("after_br", I_ADDI, 64'h204);

    // Flush out of BR_WAIT
    push_exp(I_JAL, 64'h300, 64'h300, 64'h10, RF2, 64'h10, 1'b1, 1'b0);
    issue("jal", I_JAL, 64'h300);
    EXE_READY = 1'b0;
    drive_de(1'b1, I_ADDI, 64'h304);
    settle();
    chk("flush.de_ready_pre", 64'(DE_READY), 64'd0);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("flush.exe_v", 64'(EXE_V), 64'd0);
    EXE_READY = 1'b1;
    push_exp(I_ADDI, 64'h304, 64'd0, ONES, RF2, ONES, 1'b0, 1'b0);
    issue("after_flush", I_ADDI, 64'h304);

    // Trap wait released by TRAP_DONE
    push_exp(I_ECALL, 64'h400, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    issue("ecall", I_ECALL, 64'h400);
    drive_de(1'b1, I_ADDI, 64'h404);
    settle();
    chk("trap.de_ready", 64'(DE_READY), 64'd0);
    TRAP_DONE = 1'b1;
    tick();
    TRAP_DONE = 1'b0;
    push_exp(I_ECALL, 64'h408, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    issue("ecall2", I_ECALL, 64'h408);

    // Reset while in TRAP_WAIT with a stalled EXE latch
    EXE_READY = 1'b0;
    drive_de(1'b0, I_ADDI, 64'h40C);
    tick();
    chk("trst.exe_v_pre", 64'(EXE_V), 64'd1);
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    chk("trst.exe_v",   64'(EXE_V),    64'd0);
    chk("trst.haz_cnt", 64'(HAZ_CNT),  64'd0);
    chk("trst.exe_ir",  64'(EXE_IR),   64'h13);
    chk("trst.trap",    64'(EXE_TRAP), 64'd0);
    EXE_READY = 1'b1;
    drive_de(1'b1, I_ADDI, 64'h40C);
    settle();
    chk("trst.run", 64'(DE_READY), 64'd1);

    // Saturating bubble counter (4 bits)
    FWD_V = 3'b001; FWD_RD = {5'd0, 5'd0, 5'd5}; FWD_PEND = 3'b001;
    drive_de(1'b1, I_ADD52, 64'h500);
    for (int i = 0; i < 17; i++) tick();
    chk("sat.haz_cnt", 64'(HAZ_CNT), 64'hF);
    tick();
    chk("sat.haz_hold", 64'(HAZ_CNT), 64'hF);
    chk("sat.de_ready", 64'(DE_READY), 64'd0);
    drive_de(1'b0, 32'h0, 64'h0);
    FWD_PEND = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
